decode_ctrl_queue: RTL
======================

Name: decode_ctrl_queue

Overview:
- Registered successor to the combinational instruction decoder in the ID stage of the RISC-V pipeline CPU.
- Decodes each fetched RV32I instruction into the ID control bundle and buffers it in a parametrised FIFO with valid/ready handshakes on both sides.
- Flags illegal encodings instead of latching stale controls, captures the PC of the first illegal instruction, and counts decoded instructions.
- Sits between the IF/ID register and the ID/EX segment register; lets IF run ahead while EX stalls.

Parameters:
- PC_W, 32, width of the PC carried with each entry.
- DEPTH, 2, number of FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the saturating decoded-instruction counter.

Ports:
- CPU_CLK  in  1  clock; all state updates on the rising edge.
- CPU_RST  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction and PC presented.
- in_ready  out  1  FIFO can accept this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  instruction PC.
- flush  in  1  branch/jump redirect; discard all buffered entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  ID/EX register consumes the head this cycle.
- out_ctrl  out  CTRL_W  head control bundle.
- out_rd, out_rs1, out_rs2  out  5 each  register indices, decoded from the instruction.
- out_pc  out  PC_W  head PC.
- out_illegal  out  1  head instruction is illegal.
- out_md_valid  out  1  head is an M-extension operation.
- out_md_op  out  3  funct3 of the M operation.
- illegal_seen  out  1  sticky: an illegal instruction has been dequeued.
- illegal_pc  out  PC_W  PC of the first dequeued illegal instruction.
- clr_illegal  in  1  clears illegal_seen and illegal_pc.
- dec_count  out  CNT_W  number of dequeued legal instructions, saturating.

Behaviour:
- Clock and reset: one clock, CPU_CLK. CPU_RST is synchronous and active-high. On reset: FIFO empty, pointers 0, out_valid=0, in_ready=1, illegal_seen=0, illegal_pc=0, dec_count=0.
- Head outputs: when out_valid=0, the head data outputs are don't-care. The bench checks them only when out_valid=1.
- Decode:
  - Combinational on in_instr; the decoded result is written into the FIFO on accept.
  - Field codes for AluContrl, BranchType, RegWrite and ImmType come from Parameters.v.
  - Every output has a default assignment. No latches, including for unused funct3 values.
- Illegal encodings:
  - Unknown opcode.
  - Load funct3 of 3, 6 or 7.
  - Store funct3 greater than 2.
  - Branch funct3 of 2 or 3.
  - JALR funct3 other than 0.
  - R-type funct7 other than 0x00 or 0x20; 0x20 is legal only with funct3 0 or 5.
  - SLLI with funct7 other than 0x00; SRLI/SRAI with funct7 other than 0x00 or 0x20.
- Illegal entry contents: ctrl is the NOP bundle (RegWrite=0, MemWrite=0, NOBRANCH, Jal=Jalr=0, RegRead=0) and illegal=1.
- Accept: in_valid & in_ready & ~flush. Entry is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Dequeue: out_valid & out_ready & ~flush. rd_ptr increments modulo DEPTH.
- Occupancy: a count of width clog2(DEPTH)+1.
  - in_ready = (count != DEPTH). Registered-free, derived from count.
  - out_valid = (count != 0).
- Simultaneous accept and dequeue while full: not permitted. in_ready=0 when full, with no bypass.
- Simultaneous accept and dequeue while empty: the accept proceeds. The dequeue cannot occur because out_valid=0.
- Latency: an instruction accepted in cycle N is visible at the head in cycle N+1. There is no combinational in-to-out path.
- Flush: next cycle count=0, rd_ptr=wr_ptr=0, out_valid=0. The same-cycle input is dropped. Flush has priority over accept and dequeue.
- Illegal capture: on dequeue of an illegal entry with illegal_seen=0, set illegal_seen=1 and illegal_pc=out_pc. Later illegal entries are ignored until clr_illegal.
- clr_illegal vs capture in the same cycle: clr wins, and the new capture is lost.
- Counter: dec_count increments on each legal dequeue and saturates at 2^CNT_W-1. It is not affected by flush.
- Reset mid-stream: all state returns to reset values on the next edge. Entries in flight are discarded.

Optional Feature:
- Macro: DECODE_RV32M_EN.
- Defined:
  - R-type with funct7=0x01 is legal, with out_md_valid=1 and out_md_op=funct3.
  - ctrl has RegRead=11, RegWrite=LW and AluContrl=ADD; EX ignores AluContrl when md_valid=1.
- Undefined:
  - funct7=0x01 is illegal.
  - out_md_valid and out_md_op are tied to 0.
  - No M-extension logic is synthesised.

Decomposition:
- Package decode_pkg holds:
  - CTRL_W=26.
  - Bundle field offsets: Jal, Jalr, RegWrite[3], MemToReg, MemWrite[4], LoadNpc, RegRead[2], BranchType[3], AluContrl[4], AluSrc1, AluSrc2[2], ImmType[3].
  - Opcode constants.
  - The NOP bundle constant.
- Sub-module rv32_decode: purely combinational instr→{ctrl, illegal, md_valid, md_op}. The queue module instantiates it once.

Test Plan:
- Reset, then in_valid for 0x00500093 (addi x1,x0,5) at pc=0x0 with out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, AluContrl=ADD, AluSrc2=10, RegWrite=LW, out_illegal=0; the cycle after, dec_count=1.
- out_ready=0, push 0x0040A103 (lw) and 0x00208663 (beq) → count=2, in_ready=0, a third push is not accepted. Release out_ready → dequeue order is lw (MemToReg=1) then beq (BranchType=BEQ). Repeat 5 times to exercise pointer wrap.
- Push 0xFFFFFFFF at pc=0x40, then 0x0000707F at pc=0x44 → both dequeue with illegal=1 and NOP ctrl. illegal_seen=1, illegal_pc=0x40. clr_illegal pulse → both clear.
- Fill with DEPTH entries, then assert flush together with in_valid → next cycle out_valid=0, in_ready=1, nothing from the flush cycle enqueued.
- Push 0x022081B3 (mul x3,x1,x2) → with DECODE_RV32M_EN: md_valid=1, md_op=0, illegal=0. Without it: illegal=1, md_valid=0.
- Force dec_count to 2^CNT_W-2 with CNT_W=2 (count 2), dequeue 3 legal instructions → dec_count stays 3. Assert CPU_RST mid-stream with 2 entries → next cycle all outputs at reset values.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the ID-stage decode queue: control bundle layout,
// RV32I opcode constants and the field codes carried in the bundle.
package decode_pkg;

  localparam int CTRL_W = 26;

  // Bit offsets of each bundle field, MSB first.
  localparam int JAL_BIT      = 25;
  localparam int JALR_BIT     = 24;
  localparam int REGWRITE_LSB = 21;
  localparam int MEMTOREG_BIT = 20;
  localparam int MEMWRITE_LSB = 16;
  localparam int LOADNPC_BIT  = 15;
  localparam int REGREAD_LSB  = 13;
  localparam int BRANCH_LSB   = 10;
  localparam int ALU_LSB      = 6;
  localparam int ALUSRC1_BIT  = 5;
  localparam int ALUSRC2_LSB  = 3;
  localparam int IMM_LSB      = 0;

  typedef struct packed {
    logic       jal;
    logic       jalr;
    logic [2:0] reg_write;
    logic       mem_to_reg;
    logic [3:0] mem_write;
    logic       load_npc;
    logic [1:0] reg_read;
    logic [2:0] branch_type;
    logic [3:0] alu_ctrl;
    logic       alu_src1;
    logic [1:0] alu_src2;
    logic [2:0] imm_type;
  } ctrl_t;

  // Opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // AluContrl codes
  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRL  = 4'd1;
  localparam logic [3:0] ALU_SRA  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  // BranchType codes
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BLTU = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  // RegWrite codes (load width / writeback enable)
  localparam logic [2:0] RW_NONE = 3'd0;
  localparam logic [2:0] RW_LB   = 3'd1;
  localparam logic [2:0] RW_LH   = 3'd2;
  localparam logic [2:0] RW_LW   = 3'd3;
  localparam logic [2:0] RW_LBU  = 3'd4;
  localparam logic [2:0] RW_LHU  = 3'd5;

  // ImmType codes
  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  // AluSrc2 select: register, rs2 field as shamt, immediate
  localparam logic [1:0] SRC2_REG   = 2'b00;
  localparam logic [1:0] SRC2_SHAMT = 2'b01;
  localparam logic [1:0] SRC2_IMM   = 2'b10;

  // Bundle that cannot write, branch, jump or read registers.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/rv32_decode.sv
// Combinational RV32I decoder: instruction -> control bundle, register
// indices, illegal flag. M-extension decode is built only when
// DECODE_RV32M_EN is defined; otherwise funct7=0x01 is illegal.
module rv32_decode
  import decode_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic              illegal,
  output logic              md_valid,
  output logic [2:0]        md_op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctrl_t      c;
  logic       ill;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

`ifdef DECODE_RV32M_EN
  logic md;
`endif

  // Opcode/funct decode; any illegal encoding collapses to the NOP bundle.
  always_comb begin
    c          = CTRL_NOP;
    c.alu_ctrl = ALU_ADD;
    ill        = 1'b0;
`ifdef DECODE_RV32M_EN
    md         = 1'b0;
`endif
    case (opcode)
      OP_LUI: begin
        c.reg_write = RW_LW; c.imm_type = IMM_U; c.alu_src2 = SRC2_IMM; c.alu_ctrl = ALU_LUI;
      end
      OP_AUIPC: begin
        c.reg_write = RW_LW; c.imm_type = IMM_U; c.alu_src1 = 1'b1; c.alu_src2 = SRC2_IMM;
      end
      OP_JAL: begin
        c.jal = 1'b1; c.reg_write = RW_LW; c.load_npc = 1'b1; c.imm_type = IMM_J;
      end
      OP_JALR: begin
        c.jalr = 1'b1; c.reg_write = RW_LW; c.load_npc = 1'b1; c.imm_type = IMM_I;
        c.alu_src2 = SRC2_IMM; c.reg_read = 2'b10;
        if (funct3 != 3'b000) ill = 1'b1;
      end
      OP_BRANCH: begin
        c.reg_read = 2'b11; c.imm_type = IMM_B;
        case (funct3)
          3'b000:  c.branch_type = BR_BEQ;
          3'b001:  c.branch_type = BR_BNE;
          3'b100:  c.branch_type = BR_BLT;
          3'b101:  c.branch_type = BR_BGE;
          3'b110:  c.branch_type = BR_BLTU;
          3'b111:  c.branch_type = BR_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        c.mem_to_reg = 1'b1; c.imm_type = IMM_I; c.alu_src2 = SRC2_IMM; c.reg_read = 2'b10;
        case (funct3)
          3'b000:  c.reg_write = RW_LB;
          3'b001:  c.reg_write = RW_LH;
          3'b010:  c.reg_write = RW_LW;
          3'b100:  c.reg_write = RW_LBU;
          3'b101:  c.reg_write = RW_LHU;
          default: ill = 1'b1;
        endcase
      end
      OP_STORE: begin
        c.imm_type = IMM_S; c.alu_src2 = SRC2_IMM; c.reg_read = 2'b11;
        case (funct3)
          3'b000:  c.mem_write = 4'b0001;
          3'b001:  c.mem_write = 4'b0011;
          3'b010:  c.mem_write = 4'b1111;
          default: ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        c.reg_write = RW_LW; c.imm_type = IMM_I; c.alu_src2 = SRC2_IMM; c.reg_read = 2'b10;
        case (funct3)
          3'b000: c.alu_ctrl = ALU_ADD;
          3'b010: c.alu_ctrl = ALU_SLT;
          3'b011: c.alu_ctrl = ALU_SLTU;
          3'b100: c.alu_ctrl = ALU_XOR;
          3'b110: c.alu_ctrl = ALU_OR;
          3'b001: begin
            c.alu_ctrl = ALU_SLL; c.alu_src2 = SRC2_SHAMT;
            if (funct7 != 7'h00) ill = 1'b1;
          end
          3'b101: begin
            c.alu_src2 = SRC2_SHAMT;
            if (funct7 == 7'h00)      c.alu_ctrl = ALU_SRL;
            else if (funct7 == 7'h20) c.alu_ctrl = ALU_SRA;
            else                      ill = 1'b1;
          end
          default: c.alu_ctrl = ALU_AND;
        endcase
      end
      OP_REG: begin
        c.reg_write = RW_LW; c.imm_type = IMM_R; c.alu_src2 = SRC2_REG; c.reg_read = 2'b11;
        case (funct7)
          7'h00: begin
            case (funct3)
              3'b000:  c.alu_ctrl = ALU_ADD;
              3'b001:  c.alu_ctrl = ALU_SLL;
              3'b010:  c.alu_ctrl = ALU_SLT;
              3'b011:  c.alu_ctrl = ALU_SLTU;
              3'b100:  c.alu_ctrl = ALU_XOR;
              3'b101:  c.alu_ctrl = ALU_SRL;
              3'b110:  c.alu_ctrl = ALU_OR;
              default: c.alu_ctrl = ALU_AND;
            endcase
          end
          7'h20: begin
            if (funct3 == 3'b000)      c.alu_ctrl = ALU_SUB;
            else if (funct3 == 3'b101) c.alu_ctrl = ALU_SRA;
            else                       ill = 1'b1;
          end
`ifdef DECODE_RV32M_EN
          // EX routes to the multiplier/divider; AluContrl stays ADD.
          7'h01: md = 1'b1;
`endif
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) c = CTRL_NOP;
  end

  assign ctrl    = c;
  assign illegal = ill;

`ifdef DECODE_RV32M_EN
  assign md_valid = md;
  assign md_op    = md ? funct3 : 3'b000;
`else
  assign md_valid = 1'b0;
  assign md_op    = 3'b000;
`endif

endmodule

// File: rtl/decode_ctrl_queue.sv
// Registered ID-stage decoder: decodes each accepted instruction and buffers
// the result in a DEPTH-entry FIFO between IF/ID and ID/EX. Tracks the PC of
// the first dequeued illegal instruction and a saturating count of dequeued
// legal instructions. Optional M-extension decode: define DECODE_RV32M_EN.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high (and flush is low); valid must not depend on ready, in_ready depends
// only on occupancy, and there is no combinational path from input to output.
module decode_ctrl_queue
  import decode_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_illegal,
  output logic              out_md_valid,
  output logic [2:0]        out_md_op,
  output logic              illegal_seen,
  output logic [PC_W-1:0]   illegal_pc,
  input  logic              clr_illegal,
  output logic [CNT_W-1:0]  dec_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = CTRL_W + 15 + PC_W + 5;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  logic [CTRL_W-1:0]  dec_ctrl;
  logic [4:0]         dec_rd, dec_rs1, dec_rs2;
  logic               dec_illegal, dec_md_valid;
  logic [2:0]         dec_md_op;
  logic [ENTRY_W-1:0] wr_entry, head;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               illegal_seen_q, illegal_seen_d;
  logic [PC_W-1:0]    illegal_pc_q, illegal_pc_d;
  logic [CNT_W-1:0]   dec_count_q, dec_count_d;
  logic               push, pop;

  rv32_decode u_decode (
    .instr    (in_instr),
    .ctrl     (dec_ctrl),
    .rd       (dec_rd),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .illegal  (dec_illegal),
    .md_valid (dec_md_valid),
    .md_op    (dec_md_op)
  );

  assign wr_entry = {dec_ctrl, dec_rd, dec_rs1, dec_rs2, in_pc, dec_illegal, dec_md_valid, dec_md_op};
  assign head     = mem_q[rd_ptr_q];
  assign {out_ctrl, out_rd, out_rs1, out_rs2, out_pc, out_illegal, out_md_valid, out_md_op} = head;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Storage write at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_entry;
  end

  // Pointer and occupancy update; flush empties the queue and wins over both sides.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + OCC_W'(1);
      else if (pop && !push) count_d = count_q - OCC_W'(1);
    end
  end

  // First-illegal capture (clear wins over capture) and saturating legal count.
  always_comb begin
    illegal_seen_d = illegal_seen_q;
    illegal_pc_d   = illegal_pc_q;
    dec_count_d    = dec_count_q;
    if (clr_illegal) begin
      illegal_seen_d = 1'b0;
      illegal_pc_d   = '0;
    end else if (pop && out_illegal && !illegal_seen_q) begin
      illegal_seen_d = 1'b1;
      illegal_pc_d   = out_pc;
    end
    if (pop && !out_illegal && (dec_count_q != '1)) dec_count_d = dec_count_q + CNT_W'(1);
  end

  // Entry storage needs no reset: out_valid masks stale contents.
  always_ff @(posedge CPU_CLK) begin
    mem_q <= mem_d;
  end

  // Control state with synchronous reset.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      illegal_seen_q <= 1'b0;
      illegal_pc_q   <= '0;
      dec_count_q    <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      illegal_seen_q <= illegal_seen_d;
      illegal_pc_q   <= illegal_pc_d;
      dec_count_q    <= dec_count_d;
    end
  end

  assign illegal_seen = illegal_seen_q;
  assign illegal_pc   = illegal_pc_q;
  assign dec_count    = dec_count_q;

endmodule
